uart_tx_buffered: RTL and testbench

Buffered UART transmitter for the CPU's serial console path. It accepts bytes through a valid/ready push port into an internal FIFO. It serialises them onto `TxD` at a fixed baud rate with LSB first, one start bit, optional parity and 1 or 2 stop bits. It pairs with the console receiver on the same line settings and lets software queue a burst of characters without polling per byte.

---
 rtl/uart_tx_buffered_if.sv | 18 +
 rtl/uart_tx_buffered.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// Push-side bundle of the buffered UART transmitter: byte handshake, FIFO clear
// and occupancy report.
interface uart_tx_buffered_if #(
  parameter int Depth = 16
);
  localparam int LevelW = $clog2(Depth) + 1;

  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              flush;
  logic [LevelW-1:0] level;

  modport master (output wr_valid, output wr_data, output flush,
                  input  wr_ready, input  level);
  modport slave  (input  wr_valid, input  wr_data, input  flush,
                  output wr_ready, output level);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes are queued in a FIFO, then sent LSB first with
// one start bit, optional parity and 1 or 2 stop bits at a fixed baud rate.
module uart_tx_buffered #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Depth        = 16,
  parameter bit ParityEn     = 1'b0,
  parameter bit ParityOdd    = 1'b0,
  parameter int StopBits     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_buffered_if.slave  bus,
  output logic               TxD,
  output logic               busy
);

  localparam int Div     = (ClkFrequency + Baud / 2) / Baud;
  localparam int CntW    = $clog2(Div);
  localparam int PtrW    = $clog2(Depth);
  localparam int LvlW    = PtrW + 1;
  localparam bit TwoStop = (StopBits == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wrPtrQ;
  logic [PtrW-1:0] rdPtrQ;
  logic [LvlW-1:0] levelQ;
  logic [7:0]      head;
  logic            push;
  logic            pop;

  state_t          stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic [2:0]      idxQ, idxD;
  logic            stopIdxQ, stopIdxD;
  logic [7:0]      shiftQ, shiftD;
  logic            parQ, parD;
  logic            txdD;
  logic            bitEnd;

  assign head         = mem[rdPtrQ];
  assign bus.wr_ready = (levelQ != LvlW'(Depth));
  assign bus.level    = levelQ;
  assign push         = bus.wr_valid & bus.wr_ready & ~bus.flush;
  assign bitEnd       = (cntQ == CntW'(Div - 1));
  assign busy         = (levelQ != '0) | (stateQ != IDLE);

  // FIFO bookkeeping; flush wins over push but never blocks the FSM's pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      levelQ <= '0;
    end else if (bus.flush) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      levelQ <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + PtrW'(1);
      if (pop)  rdPtrQ <= rdPtrQ + PtrW'(1);
      levelQ <= levelQ + LvlW'(push) - LvlW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtrQ] <= bus.wr_data;
  end

  always_comb begin
    stateD   = stateQ;
    cntD     = bitEnd ? '0 : cntQ + CntW'(1);
    idxD     = idxQ;
    stopIdxD = stopIdxQ;
    shiftD   = shiftQ;
    parD     = parQ;
    pop      = 1'b0;
    case (stateQ)
      IDLE: begin
        cntD = '0;
        if (levelQ != '0) begin
          pop    = 1'b1;
          shiftD = head;
          parD   = (^head) ^ ParityOdd;
          stateD = START;
        end
      end
      START: begin
        if (bitEnd) begin
          stateD = DATA;
          idxD   = 3'd0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shiftD = {1'b0, shiftQ[7:1]};
          idxD   = idxQ + 3'd1;
          if (idxQ == 3'd7) begin
            stateD   = ParityEn ? PARITY : STOP;
            stopIdxD = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          stateD   = STOP;
          stopIdxD = 1'b0;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (TwoStop && !stopIdxQ) begin
            stopIdxD = 1'b1;
          end else if (levelQ != '0) begin
            // Chain straight into the next start bit so bursts have no idle gap
            pop    = 1'b1;
            shiftD = head;
            parD   = (^head) ^ ParityOdd;
            cntD   = '0;
            stateD = START;
          end else begin
            stateD = IDLE;
          end
        end
      end
      default: stateD = IDLE;
    endcase

    // Line level is registered from the next state so every bit lasts exactly Div clocks
    case (stateD)
      START:   txdD = 1'b0;
      DATA:    txdD = shiftD[0];
      PARITY:  txdD = parD;
      default: txdD = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      cntQ     <= '0;
      idxQ     <= '0;
      stopIdxQ <= 1'b0;
      TxD      <= 1'b1;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      idxQ     <= idxD;
      stopIdxQ <= stopIdxD;
      TxD      <= txdD;
    end
  end

  always_ff @(posedge clk) begin
    shiftQ <= shiftD;
    parQ   <= parD;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at Div=10: frame tables per configuration,
// plus burst, full, flush and mid-frame reset sequences.
module tb_uart_tx_buffered;

  localparam int Div = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  uart_tx_buffered_if #(.Depth(4))  ifA ();
  uart_tx_buffered_if #(.Depth(16)) ifP ();
  uart_tx_buffered_if #(.Depth(16)) ifO ();
  uart_tx_buffered_if #(.Depth(16)) ifS ();
  logic txdA, busyA, txdP, busyP, txdO, busyO, txdS, busyS;

  uart_tx_buffered #(.ClkFrequency(1000), .Baud(100), .Depth(4)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA.slave), .TxD(txdA), .busy(busyA));
  uart_tx_buffered #(.ClkFrequency(1000), .Baud(100), .ParityEn(1'b1)) dutP (
    .clk(clk), .rst_n(rst_n), .bus(ifP.slave), .TxD(txdP), .busy(busyP));
  uart_tx_buffered #(.ClkFrequency(1000), .Baud(100), .ParityEn(1'b1), .ParityOdd(1'b1)) dutO (
    .clk(clk), .rst_n(rst_n), .bus(ifO.slave), .TxD(txdO), .busy(busyO));
  uart_tx_buffered #(.ClkFrequency(1000), .Baud(100), .ParityEn(1'b1), .StopBits(2)) dutS (
    .clk(clk), .rst_n(rst_n), .bus(ifS.slave), .TxD(txdS), .busy(busyS));

  int   sel;
  logic txdSel, busySel;
  int   levelSel;

  always_comb begin
    case (sel)
      1:       begin txdSel = txdP; busySel = busyP; levelSel = int'(ifP.level); end
      2:       begin txdSel = txdO; busySel = busyO; levelSel = int'(ifO.level); end
      3:       begin txdSel = txdS; busySel = busyS; levelSel = int'(ifS.level); end
      default: begin txdSel = txdA; busySel = busyA; levelSel = int'(ifA.level); end
    endcase
  end

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [63:0] bits;   // line bits, bit 0 = start bit
    int          nBits;
  } vec_t;

  vec_t tbl [6];
  int   checks = 0;
  int   errors = 0;
  int   lvlLog [0:511];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic setValid(input int s, input logic v, input logic [7:0] d);
    case (s)
      1:       begin ifP.wr_valid = v; ifP.wr_data = d; end
      2:       begin ifO.wr_valid = v; ifO.wr_data = d; end
      3:       begin ifS.wr_valid = v; ifS.wr_data = d; end
      default: begin ifA.wr_valid = v; ifA.wr_data = d; end
    endcase
  endtask

  task automatic pushOne(input int s, input logic [7:0] d);
    setValid(s, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    setValid(s, 1'b0, 8'h00);
  endtask

  // Samples the selected line once per clock for nBits*Div clocks from the current negedge
  task automatic checkStream(input string name, input logic [63:0] bits,
                             input int nBits, input int busyClks);
    int badBusy;
    int k;
    int act;
    badBusy = 0;
    for (int b = 0; b < nBits; b++) begin
      act = int'(bits[b]);
      for (int c = 0; c < Div; c++) begin
        k = b * Div + c;
        if (txdSel !== bits[b]) act = int'(txdSel);
        if (busySel !== (k < busyClks)) badBusy++;
        if (k < 512) lvlLog[k] = levelSel;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", name, b), act, int'(bits[b]));
    end
    check($sformatf("%s_busy", name), badBusy, 0);
  endtask

  task automatic runFrame(input vec_t v, input string name);
    sel = v.sel;
    pushOne(v.sel, v.data);
    check({name, "_lvl1"}, levelSel, 1);
    check({name, "_idle"}, int'(txdSel), 1);
    check({name, "_busy0"}, int'(busySel), 1);
    @(negedge clk);
    check({name, "_lvl0"}, levelSel, 0);
    checkStream(name, v.bits, v.nBits, v.nBits * Div);
    check({name, "_endTxd"}, int'(txdSel), 1);
    check({name, "_endBusy"}, int'(busySel), 0);
  endtask

  task automatic rxByte(output logic [7:0] d, output int ok);
    int n;
    n = 0;
    d = 8'h00;
    ok = 0;
    while (txdSel !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) return;
    repeat (Div / 2) @(negedge clk);
    if (txdSel !== 1'b0) return;
    for (int b = 0; b < 8; b++) begin
      repeat (Div) @(negedge clk);
      d[b] = txdSel;
    end
    repeat (Div) @(negedge clk);
    ok = int'(txdSel === 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int ok;
    int accepted;
    int idleBad;

    tbl[0] = '{0, 8'h55, 64'h2AA, 10};
    tbl[1] = '{0, 8'hA3, 64'h346, 10};
    tbl[2] = '{1, 8'h07, 64'h60E, 11};
    tbl[3] = '{1, 8'h03, 64'h406, 11};
    tbl[4] = '{2, 8'h07, 64'h40E, 11};
    tbl[5] = '{3, 8'h07, 64'hE0E, 12};

    sel = 0;
    rst_n = 1'b0;
    ifA.wr_valid = 1'b0; ifA.wr_data = 8'h00; ifA.flush = 1'b0;
    ifP.wr_valid = 1'b0; ifP.wr_data = 8'h00; ifP.flush = 1'b0;
    ifO.wr_valid = 1'b0; ifO.wr_data = 8'h00; ifO.flush = 1'b0;
    ifS.wr_valid = 1'b0; ifS.wr_data = 8'h00; ifS.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", int'(txdA), 1);
    check("rst_ready", int'(ifA.wr_ready), 1);
    check("rst_level", int'(ifA.level), 0);
    check("rst_busy", int'(busyA), 0);
    check("rst_txdS", int'(txdS), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) runFrame(tbl[i], $sformatf("frame%0d", i));

    // Back-to-back 0x00, 0xFF, 0xA3
    sel = 0;
    setValid(0, 1'b1, 8'h00);
    @(posedge clk); @(negedge clk);
    check("b2b_lvlE", levelSel, 1);
    setValid(0, 1'b1, 8'hFF);
    @(posedge clk); @(negedge clk);
    check("b2b_lvlE1", levelSel, 1);
    fork
      checkStream("b2b", {34'd0, 10'h346, 10'h3FE, 10'h200}, 30, 300);
      begin
        setValid(0, 1'b1, 8'hA3);
        @(posedge clk); @(negedge clk);
        setValid(0, 1'b0, 8'h00);
      end
    join
    check("b2b_lvl_k1", lvlLog[1], 2);
    check("b2b_lvl_k99", lvlLog[99], 2);
    check("b2b_lvl_k100", lvlLog[100], 1);
    check("b2b_lvl_k199", lvlLog[199], 1);
    check("b2b_lvl_k200", lvlLog[200], 0);
    check("b2b_endBusy", int'(busySel), 0);

    // Full: Depth 4, six pushes while a 0xFF frame is in flight
    pushOne(0, 8'hFF);
    repeat (15) @(negedge clk);
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      setValid(0, 1'b1, 8'h21 + 8'(i));
      if (ifA.wr_ready) accepted++;
      if (i == 4) begin
        check("full_level4", levelSel, 4);
        check("full_readyLow", int'(ifA.wr_ready), 0);
      end
      @(posedge clk); @(negedge clk);
    end
    setValid(0, 1'b0, 8'h00);
    check("full_accepted", accepted, 4);
    check("full_levelAfter", levelSel, 4);
    for (int j = 0; j < 4; j++) begin
      rxByte(rx, ok);
      check($sformatf("full_rxOk%0d", j), ok, 1);
      check($sformatf("full_rxByte%0d", j), int'(rx), 8'h21 + j);
    end
    repeat (Div) @(negedge clk);
    check("full_doneBusy", int'(busySel), 0);
    check("full_doneLevel", levelSel, 0);

    // Flush with three bytes queued and a 0x0F frame on the line
    pushOne(0, 8'h0F);
    @(negedge clk);
    fork
      checkStream("flush", {44'd0, 10'h3FF, 10'h21E}, 20, 100);
      begin
        repeat (12) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          setValid(0, 1'b1, 8'h40 + 8'(i));
          @(posedge clk); @(negedge clk);
        end
        check("flush_queued", levelSel, 3);
        setValid(0, 1'b1, 8'h5A);
        ifA.flush = 1'b1;
        @(posedge clk); @(negedge clk);
        ifA.flush = 1'b0;
        setValid(0, 1'b0, 8'h00);
        check("flush_level0", levelSel, 0);
        repeat (2) @(negedge clk);
        check("flush_discard", levelSel, 0);
      end
    join
    check("flush_endTxd", int'(txdSel), 1);
    check("flush_endBusy", int'(busySel), 0);

    // Reset during data bit 3 of a 0x00 frame with two bytes queued behind it
    pushOne(0, 8'h00);
    pushOne(0, 8'h12);
    pushOne(0, 8'h34);
    check("rstmid_queued", levelSel, 2);
    repeat (43) @(negedge clk);
    check("rstmid_bit3", int'(txdSel), 0);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_txdAsync", int'(txdA), 1);
    check("rstmid_level", int'(ifA.level), 0);
    check("rstmid_busy", int'(busyA), 0);
    check("rstmid_ready", int'(ifA.wr_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    idleBad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txdA !== 1'b1 || busyA !== 1'b0) idleBad++;
    end
    check("rstmid_staysIdle", idleBad, 0);
    runFrame(tbl[0], "rstmid_clean");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
